shift_add_multiplier: RTL and testbench

Multi-cycle RV32M multiply functional unit for the out-of-order core. Sits directly downstream of the MUL reservation station, which issues one operation at a time with operands, multiply type and destination tags. The unit computes the 64-bit product with a radix-2 shift-add datapath, one multiplier bit per cycle. It then presents the selected 32-bit half, with the tags, to the CDB arbiter and holds it until granted.

---
 rtl/shift_add_multiplier_if.sv | 28 ++
 rtl/shift_add_multiplier.sv | 131 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// Issue/result bundle between the MUL reservation station, the multiplier and the CDB arbiter.
interface shift_add_multiplier_if;
  logic        start;
  logic [1:0]  mul_type;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  rob_id_in;
  logic [5:0]  prd_in;
  logic        flush;
  logic        ack;
  logic        ready;
  logic        valid_out;
  logic [31:0] result;
  logic [7:0]  rob_id_out;
  logic [5:0]  prd_out;

  // Station / CDB side
  modport master (
    output start, mul_type, a, b, rob_id_in, prd_in, flush, ack,
    input  ready, valid_out, result, rob_id_out, prd_out
  );

  // Functional-unit side
  modport slave (
    input  start, mul_type, a, b, rob_id_in, prd_in, flush, ack,
    output ready, valid_out, result, rob_id_out, prd_out
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add RV32M multiplier: unsigned magnitudes, sign applied once at completion.
module shift_add_multiplier (
  input logic                   clk,
  input logic                   rst_n,
  shift_add_multiplier_if.slave bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  state_t          state_next;

  logic [PW-1:0]   mcand;
  logic [W-1:0]    mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            sa;
  logic            sb;
  logic [1:0]      type_r;
  logic            valid_r;
  logic [W-1:0]    result_r;
  logic [7:0]      rob_id_r;
  logic [5:0]      prd_r;

  logic            sa_c;
  logic            sb_c;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   prod;
  logic            last;

  // Operand sign decode and magnitude conversion; MUL treats operands as raw unsigned
  always_comb begin
    sa_c  = ((bus.mul_type == 2'b01) || (bus.mul_type == 2'b10)) && bus.a[W-1];
    sb_c  = (bus.mul_type == 2'b01) && bus.b[W-1];
    a_mag = sa_c ? (~bus.a + W'(1)) : bus.a;
    b_mag = sb_c ? (~bus.b + W'(1)) : bus.b;
  end

  // One partial-product step and the sign-corrected final product
  always_comb begin
    acc_sum = acc + (mplier[0] ? mcand : PW'(0));
    prod    = (sa ^ sb) ? (~acc_sum + PW'(1)) : acc_sum;
    last    = (cnt == CW'(W - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush overrides start and ack
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_next = CALC;
        CALC:    if (last)      state_next = DONE;
        DONE:    if (bus.ack)   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: ready is purely the idle state, the rest come from registers
  always_comb begin
    bus.ready      = (state == IDLE);
    bus.valid_out  = valid_r;
    bus.result     = result_r;
    bus.rob_id_out = rob_id_r;
    bus.prd_out    = prd_r;
  end

  // Datapath: operand capture on accept, iterate in CALC, register the selected half at the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      type_r   <= 2'b00;
      result_r <= '0;
      rob_id_r <= '0;
      prd_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            type_r   <= bus.mul_type;
            rob_id_r <= bus.rob_id_in;
            prd_r    <= bus.prd_in;
            sa       <= sa_c;
            sb       <= sb_c;
            mcand    <= PW'(a_mag);
            mplier   <= b_mag;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last && !bus.flush)
            result_r <= (type_r == 2'b00) ? prod[W-1:0] : prod[PW-1:W];
        end
        default: ;
      endcase
    end
  end

  // Result-valid flag: set on completion, cleared by grant or squash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         valid_r <= 1'b0;
    else if (bus.flush)                 valid_r <= 1'b0;
    else if (state == CALC && last)     valid_r <= 1'b1;
    else if (state == DONE && bus.ack)  valid_r <= 1'b0;
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier.
`timescale 1ns/1ps
module tb_shift_add_multiplier;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  shift_add_multiplier_if bus ();

  shift_add_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Present an op for one edge (E0); returns at E0+1ns
  task automatic issue(input logic [1:0] t, input logic [31:0] av, input logic [31:0] bv,
                       input logic [7:0] rob, input logic [5:0] prd);
    bus.start     = 1'b1;
    bus.mul_type  = t;
    bus.a         = av;
    bus.b         = bv;
    bus.rob_id_in = rob;
    bus.prd_in    = prd;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  // Count edges until valid_out, bounded
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!bus.valid_out && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd32);
  endtask

  task automatic grant(input string tag);
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    chk({tag, "_valid_after_ack"}, 64'(bus.valid_out), 64'd0);
    chk({tag, "_ready_after_ack"}, 64'(bus.ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] t, input logic [31:0] av,
                        input logic [31:0] bv, input logic [7:0] rob, input logic [5:0] prd,
                        input logic [31:0] exp);
    int n;
    issue(t, av, bv, rob, prd);
    chk({tag, "_ready_busy"}, 64'(bus.ready), 64'd0);
    wait_valid(tag, n);
    chk({tag, "_result"}, 64'(bus.result), 64'(exp));
    chk({tag, "_rob"}, 64'(bus.rob_id_out), 64'(rob));
    chk({tag, "_prd"}, 64'(bus.prd_out), 64'(prd));
    grant(tag);
  endtask

  initial begin
    int n;
    int seen;
    pass_cnt      = 0;
    total_cnt     = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mul_type  = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.rob_id_in = '0;
    bus.prd_in    = '0;
    bus.flush     = 1'b0;
    bus.ack       = 1'b0;

    #12;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_rob", 64'(bus.rob_id_out), 64'd0);
    chk("rst_prd", 64'(bus.prd_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7_m3",   2'b00, 32'd7,        32'hFFFF_FFFD, 8'h11, 6'h05, 32'hFFFF_FFEB);
    run_op("mulh_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 8'h22, 6'h0A, 32'h4000_0000);
    run_op("mulhsu_m1",  2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h33, 6'h15, 32'hFFFF_FFFF);
    run_op("mulhu_max",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h44, 6'h2A, 32'hFFFF_FFFE);
    run_op("mul_zero",   2'b00, 32'd0,        32'h1234_5678, 8'h55, 6'h3F, 32'h0000_0000);

    // Backpressure: hold ack low 5 cycles, a start in the window must be ignored
    issue(2'b00, 32'd6, 32'd7, 8'hA5, 6'h1C);
    wait_valid("bp", n);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.start = 1'b1; bus.mul_type = 2'b11; bus.a = 32'd9; bus.b = 32'd9;
        bus.rob_id_in = 8'h01; bus.prd_in = 6'h01;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      chk("bp_valid", 64'(bus.valid_out), 64'd1);
      chk("bp_result", 64'(bus.result), 64'd42);
      chk("bp_rob", 64'(bus.rob_id_out), 64'hA5);
      chk("bp_ready", 64'(bus.ready), 64'd0);
    end
    bus.start = 1'b0;
    chk("bp_prd", 64'(bus.prd_out), 64'h1C);
    grant("bp");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.valid_out || !bus.ready) seen++;
    end
    chk("bp_no_ghost_op", 64'(seen), 64'd0);

    // Flush sampled at E10 of CALC
    issue(2'b11, 32'd100, 32'd100, 8'h66, 6'h06);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_ready", 64'(bus.ready), 64'd1);
    chk("flush_valid", 64'(bus.valid_out), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.valid_out) seen++;
    end
    chk("flush_never_valid", 64'(seen), 64'd0);

    // Asynchronous reset mid-CALC around E20
    issue(2'b01, 32'd1000, 32'hFFFF_FFFF, 8'h77, 6'h07);
    repeat (19) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.ready), 64'd1);
    chk("arst_valid", 64'(bus.valid_out), 64'd0);
    chk("arst_result", 64'(bus.result), 64'd0);
    chk("arst_rob", 64'(bus.rob_id_out), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mulhu_3x5", 2'b11, 32'd3, 32'd5, 8'h88, 6'h08, 32'h0000_0000);
    run_op("mul_3x5",   2'b00, 32'd3, 32'd5, 8'h99, 6'h09, 32'h0000_000F);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
